// File: rtl/led_race_if.sv
// Bus bundle between the race controller and the board: run/boost/freeze
// controls in, LED track, score fields and match status out.
interface led_race_if #(
    parameter int NUM_RACERS = 2,
    parameter int TRACK_LEN  = 12,
    parameter int PW         = 2
) ();
    logic                       en;
    logic [NUM_RACERS-1:0]      speed;
    logic [NUM_RACERS-1:0]      freeze;
    logic [TRACK_LEN-1:0]       track_led;
    logic [NUM_RACERS*PW-1:0]   points;
    logic                       winner_valid;
    logic [1:0]                 winner_id;
    logic                       match_win;
    logic [1:0]                 state;

    modport master (
        output en, speed, freeze,
        input  track_led, points, winner_valid, winner_id, match_win, state
    );

    modport slave (
        input  en, speed, freeze,
        output track_led, points, winner_valid, winner_id, match_win, state
    );
endinterface

// File: rtl/led_race_engine.sv
// LED race controller: N racers step down a shared track on slow ticks,
// spend a boost budget on fast ticks, and score rounds toward a match win.
//
// state       | meaning
// IDLE        | racers parked at start, waiting for en on a slow tick
// RACE        | racers advancing; first arrival at cell 0 decides the round
// ROUND_END   | track and budgets restored, restart on next slow tick
// MATCH_WIN   | all LEDs lit for WIN_HOLD slow ticks, then scores cleared
module led_race_engine #(
    parameter int NUM_RACERS  = 2,
    parameter int TRACK_LEN   = 12,
    parameter int WIN_POINTS  = 3,
    parameter int PW          = 2,
    parameter int SLOW_DIV    = 2**27,
    parameter int FAST_DIV    = 2**24,
    parameter int BOOST_STEPS = 4,
    parameter int WIN_HOLD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    led_race_if.slave  bus
);
    localparam int CW   = $clog2(SLOW_DIV);
    localparam int FW   = $clog2(FAST_DIV);
    localparam int POSW = (TRACK_LEN > 1) ? $clog2(TRACK_LEN) : 1;
    localparam int BW   = $clog2(BOOST_STEPS + 1);
    localparam int HW   = $clog2(WIN_HOLD + 1);
    localparam int IW   = (NUM_RACERS > 1) ? $clog2(NUM_RACERS) : 1;

    localparam logic [POSW-1:0] POS_START = POSW'(TRACK_LEN - 1);
    localparam logic [BW-1:0]   BUD_FULL  = BW'(BOOST_STEPS);
    localparam logic [PW-1:0]   PTS_LAST  = PW'(WIN_POINTS - 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(WIN_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RACE      = 2'd1,
        S_ROUND_END = 2'd2,
        S_MATCH_WIN = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [POSW-1:0] pos_q [NUM_RACERS];
    logic [POSW-1:0] pos_d [NUM_RACERS];
    logic [BW-1:0]   bud_q [NUM_RACERS];
    logic [BW-1:0]   bud_d [NUM_RACERS];
    logic [PW-1:0]   pts_q [NUM_RACERS];
    logic [HW-1:0]   hold_q;
    logic            wv_q;
    logic [1:0]      wid_q;

    logic            slow_tick;
    logic            fast_tick;
    logic            any_home;
    logic [IW-1:0]   win_sel;

    assign slow_tick = &cnt_q;
    assign fast_tick = &cnt_q[FW-1:0];

    // Descending scan leaves the lowest-index racer at cell 0 as the winner.
    always_comb begin
        any_home = 1'b0;
        win_sel  = '0;
        for (int i = NUM_RACERS - 1; i >= 0; i--) begin
            if (pos_q[i] == '0) begin
                any_home = 1'b1;
                win_sel  = IW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RACERS; i++) begin
            pos_d[i] = pos_q[i];
            bud_d[i] = bud_q[i];
            if (state_q == S_RACE && bus.en && !bus.freeze[i] && !any_home
                && pos_q[i] != '0) begin
                if (bus.speed[i] && bud_q[i] != '0) begin
                    if (fast_tick) begin
                        pos_d[i] = pos_q[i] - POSW'(1);
                        bud_d[i] = bud_q[i] - BW'(1);
                    end
                end else if (slow_tick) begin
                    pos_d[i] = pos_q[i] - POSW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            wv_q    <= 1'b0;
            wid_q   <= '0;
            for (int i = 0; i < NUM_RACERS; i++) begin
                pos_q[i] <= POS_START;
                bud_q[i] <= BUD_FULL;
                pts_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_q + CW'(1);
            wv_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (slow_tick && bus.en)
                        state_q <= S_RACE;
                end
                S_RACE: begin
                    if (any_home) begin
                        wv_q  <= 1'b1;
                        wid_q <= 2'(win_sel);
                        for (int i = 0; i < NUM_RACERS; i++) begin
                            pos_q[i] <= POS_START;
                            bud_q[i] <= BUD_FULL;
                        end
                        if (pts_q[win_sel] == PTS_LAST) begin
                            state_q <= S_MATCH_WIN;
                            hold_q  <= HOLD_LOAD;
                        end else begin
                            pts_q[win_sel] <= pts_q[win_sel] + PW'(1);
                            state_q        <= S_ROUND_END;
                        end
                    end else begin
                        for (int i = 0; i < NUM_RACERS; i++) begin
                            pos_q[i] <= pos_d[i];
                            bud_q[i] <= bud_d[i];
                        end
                    end
                end
                S_ROUND_END: begin
                    if (slow_tick)
                        state_q <= S_RACE;
                end
                S_MATCH_WIN: begin
                    if (slow_tick) begin
                        if (hold_q == '0) begin
                            state_q <= S_IDLE;
                            for (int i = 0; i < NUM_RACERS; i++) begin
                                pos_q[i] <= POS_START;
                                bud_q[i] <= BUD_FULL;
                                pts_q[i] <= '0;
                            end
                        end else begin
                            hold_q <= hold_q - HW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.track_led = '0;
        for (int i = 0; i < NUM_RACERS; i++)
            bus.track_led[pos_q[i]] = 1'b1;
        if (state_q == S_MATCH_WIN)
            bus.track_led = '1;
    end

    always_comb begin
        bus.points = '0;
        for (int i = 0; i < NUM_RACERS; i++)
            bus.points[i*PW +: PW] = pts_q[i];
    end

    assign bus.winner_valid = wv_q;
    assign bus.winner_id    = wid_q;
    assign bus.match_win    = (state_q == S_MATCH_WIN);
    assign bus.state        = state_q;
endmodule
